video_timing_gen: RTL and testbench

Source end of the video stream protocol consumed by the overlay stages in the tracker pipeline: generates `de`/`hsync`/`vsync` with matching 1-based pixel coordinates and a selectable test-pattern pixel. It sits at the head of the display path, or replaces the camera input in bring-up, so downstream box/marker overlays can be exercised without external video. All outputs are registered and mutually aligned.

---
 rtl/video_pkg.sv | 43 ++++
 rtl/video_pattern_gen.sv | 67 ++++++
 rtl/video_timing_gen.sv | 155 +++++++++++++++
 tb/tb_video_timing_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video stream types for the generator and the overlay stages:
// pixel format, bar colours, test-pattern selection and coordinate widths.
package video_pkg;

  localparam int X_W = 12;
  localparam int Y_W = 11;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    PAT_BLACK    = 2'd0,
    PAT_BARS     = 2'd1,
    PAT_GRADIENT = 2'd2,
    PAT_CHECKER  = 2'd3
  } pattern_e;

  localparam rgb_t RGB_WHITE   = 24'hFFFFFF;
  localparam rgb_t RGB_YELLOW  = 24'hFFFF00;
  localparam rgb_t RGB_CYAN    = 24'h00FFFF;
  localparam rgb_t RGB_GREEN   = 24'h00FF00;
  localparam rgb_t RGB_MAGENTA = 24'hFF00FF;
  localparam rgb_t RGB_RED     = 24'hFF0000;
  localparam rgb_t RGB_BLUE    = 24'h0000FF;
  localparam rgb_t RGB_BLACK   = 24'h000000;

  // Bars run left to right in this order.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    rgb_t c;
    c = RGB_BLACK;
    case (idx)
      3'd0: c = RGB_WHITE;
      3'd1: c = RGB_YELLOW;
      3'd2: c = RGB_CYAN;
      3'd3: c = RGB_GREEN;
      3'd4: c = RGB_MAGENTA;
      3'd5: c = RGB_RED;
      3'd6: c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Test-pattern pixel source: combinational colour selection plus a bar-width
// counter that tracks which colour bar the current active pixel falls in.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 1280
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de,
  input  logic [7:0]  x_lsb,
  input  logic [7:0]  y_lsb,
  input  logic [1:0]  pattern,
  output logic [23:0] pixel
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BC_W  = $clog2(BAR_W + 1);
  localparam logic [BC_W-1:0] BAR_LAST = BC_W'(BAR_W - 1);

  logic [BC_W-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]      bar_idx_q, bar_idx_d;
  logic [7:0]      xm, ym;
  pattern_e        pat;

  // Counters restart in every blanking interval, so each line begins on bar 0.
  always_comb begin
    bar_cnt_d = '0;
    bar_idx_d = '0;
    if (de) begin
      if (bar_cnt_q == BAR_LAST) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + BC_W'(1);
        bar_idx_d = bar_idx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
    end else begin
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  // Coordinates arrive 1-based; only the low byte of the 0-based value is used.
  always_comb begin
    xm    = x_lsb - 8'd1;
    ym    = y_lsb - 8'd1;
    pat   = pattern_e'(pattern);
    pixel = '0;
    if (de) begin
      case (pat)
        PAT_BARS:     pixel = bar_colour(bar_idx_q);
        PAT_GRADIENT: pixel = {xm, ym, 8'h00};
        PAT_CHECKER:  pixel = (xm[5] ^ ym[5]) ? RGB_WHITE : RGB_BLACK;
        default:      pixel = RGB_BLACK;
      endcase
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Video timing source: h/v counters under an IDLE/RUN/DRAIN controller, one
// output register stage carrying de, syncs, coordinates and test pixel aligned.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [11:0] x_pos,
  output logic [10:0] y_pos,
  output logic        frame_start,
  output logic [23:0] pixel_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic [1:0]      pat_q, pat_d;
  logic            running, frame_last;

  always_comb begin
    state_d    = state_q;
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    running    = (state_q != ST_IDLE);
    frame_last = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    // A RUN frame that loses en on its very last clock has nothing left to drain.
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = frame_last ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (en)              state_d = ST_RUN;
        else if (frame_last) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
    if (running) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end
    // Counters sit at the origin in IDLE, so the selection also tracks there.
    pat_d = ((h_cnt_q == '0) && (v_cnt_q == '0)) ? pattern_sel : pat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      pat_q   <= PAT_BLACK;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      pat_q   <= pat_d;
    end
  end

  // ---- stage p0: decode counter state into stream signals ----
  logic           vld_p0, hsync_p0, vsync_p0, fs_p0, v_act_p0;
  logic [X_W-1:0] x_p0;
  logic [Y_W-1:0] y_p0;
  rgb_t           pix_p0;

  always_comb begin
    v_act_p0 = running && (v_cnt_q < V_ACT_END);
    vld_p0   = v_act_p0 && (h_cnt_q < H_ACT_END);
    hsync_p0 = (running && (h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_p0 = (running && (v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    fs_p0    = vld_p0 && (h_cnt_q == '0) && (v_cnt_q == '0);
    x_p0     = vld_p0 ? X_W'(h_cnt_q) + X_W'(1) : '0;
    y_p0     = v_act_p0 ? Y_W'(v_cnt_q) + Y_W'(1) : '0;
  end

  video_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .clk     (clk),
    .rst_n   (rst_n),
    .de      (vld_p0),
    .x_lsb   (x_p0[7:0]),
    .y_lsb   (y_p0[7:0]),
    .pattern (pat_d),
    .pixel   (pix_p0)
  );

  // ---- stage p1: output register ----
  logic           vld_p1, hsync_p1, vsync_p1, fs_p1;
  logic [X_W-1:0] x_p1;
  logic [Y_W-1:0] y_p1;
  rgb_t           pix_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      hsync_p1 <= ~SYNC_POL;
      vsync_p1 <= ~SYNC_POL;
      fs_p1    <= 1'b0;
      x_p1     <= '0;
      y_p1     <= '0;
      pix_p1   <= '0;
    end else begin
      vld_p1   <= vld_p0;
      hsync_p1 <= hsync_p0;
      vsync_p1 <= vsync_p0;
      fs_p1    <= fs_p0;
      x_p1     <= x_p0;
      y_p1     <= y_p0;
      pix_p1   <= pix_p0;
    end
  end

  assign de_out      = vld_p1;
  assign hsync_out   = hsync_p1;
  assign vsync_out   = vsync_p1;
  assign frame_start = fs_p1;
  assign x_pos       = x_p1;
  assign y_pos       = y_p1;
  assign pixel_out   = pix_p1;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen: two instances (small positive-sync and
// wider negative-sync geometries) checked each cycle against a frame-position model.
module tb_video_timing_gen;

  localparam int   HA[2] = '{8, 64};
  localparam int   HF[2] = '{2, 3};
  localparam int   HS[2] = '{2, 4};
  localparam int   HB[2] = '{2, 5};
  localparam int   VA[2] = '{4, 40};
  localparam int   VF[2] = '{1, 2};
  localparam int   VS[2] = '{1, 3};
  localparam int   VB[2] = '{1, 2};
  localparam logic POL[2] = '{1'b1, 1'b0};
  localparam int   FRAME_B = (64 + 3 + 4 + 5) * (40 + 2 + 3 + 2);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] pattern_sel = 2'd0;

  logic        de_a, hs_a, vs_a, fs_a, de_b, hs_b, vs_b, fs_b;
  logic [11:0] x_a, x_b;
  logic [10:0] y_a, y_b;
  logic [23:0] px_a, px_b;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HS[0]), .H_BP(HB[0]),
    .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_BP(VB[0]), .SYNC_POL(POL[0])
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
    .de_out(de_a), .hsync_out(hs_a), .vsync_out(vs_a), .x_pos(x_a), .y_pos(y_a),
    .frame_start(fs_a), .pixel_out(px_a)
  );

  video_timing_gen #(
    .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
    .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]), .SYNC_POL(POL[1])
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel),
    .de_out(de_b), .hsync_out(hs_b), .vsync_out(vs_b), .x_pos(x_b), .y_pos(y_b),
    .frame_start(fs_b), .pixel_out(px_b)
  );

  logic        o_de[2], o_hs[2], o_vs[2], o_fs[2];
  logic [11:0] o_x[2];
  logic [10:0] o_y[2];
  logic [23:0] o_px[2];
  assign o_de[0] = de_a; assign o_hs[0] = hs_a; assign o_vs[0] = vs_a; assign o_fs[0] = fs_a;
  assign o_x[0] = x_a;   assign o_y[0] = y_a;   assign o_px[0] = px_a;
  assign o_de[1] = de_b; assign o_hs[1] = hs_b; assign o_vs[1] = vs_b; assign o_fs[1] = fs_b;
  assign o_x[1] = x_b;   assign o_y[1] = y_b;   assign o_px[1] = px_b;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference: each generator is either stopped or at linear position p within
  // its frame; a frame only ends early-free, continuing iff en is high on its last clock.
  bit          m_run[2];
  int          m_p[2];
  logic [1:0]  m_pat[2];
  logic        e_de[2], e_hs[2], e_vs[2], e_fs[2];
  logic [11:0] e_x[2];
  logic [10:0] e_y[2];
  logic [23:0] e_px[2];

  function automatic logic [23:0] bar_rgb(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic model_out(input int d);
    int ht, h, v;
    logic [7:0] hb, vb;
    ht = HA[d] + HF[d] + HS[d] + HB[d];
    e_de[d] = 1'b0; e_hs[d] = ~POL[d]; e_vs[d] = ~POL[d]; e_fs[d] = 1'b0;
    e_x[d] = '0; e_y[d] = '0; e_px[d] = '0;
    if (m_run[d]) begin
      h = m_p[d] % ht;
      v = m_p[d] / ht;
      hb = 8'(h);
      vb = 8'(v);
      if (h >= HA[d] + HF[d] && h < HA[d] + HF[d] + HS[d]) e_hs[d] = POL[d];
      if (v >= VA[d] + VF[d] && v < VA[d] + VF[d] + VS[d]) e_vs[d] = POL[d];
      if (v < VA[d]) e_y[d] = 11'(v + 1);
      if (h < HA[d] && v < VA[d]) begin
        e_de[d] = 1'b1;
        e_x[d]  = 12'(h + 1);
        e_fs[d] = (h == 0 && v == 0);
        case (m_pat[d])
          2'd1: e_px[d] = bar_rgb(h / (HA[d] / 8));
          2'd2: e_px[d] = {hb, vb, 8'h00};
          2'd3: e_px[d] = (((h >> 5) ^ (v >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
          default: e_px[d] = 24'h000000;
        endcase
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 1'b0; m_p[d] = 0; m_pat[d] = 2'd0;
      model_out(d);
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int d = 0; d < 2; d++) begin
        int tot;
        tot = (HA[d] + HF[d] + HS[d] + HB[d]) * (VA[d] + VF[d] + VS[d] + VB[d]);
        if (!rst_n) begin
          m_run[d] = 1'b0;
          m_p[d]   = 0;
          model_out(d);
        end else begin
          if (m_p[d] == 0) m_pat[d] = pattern_sel;
          model_out(d);
          if (m_run[d]) begin
            if (m_p[d] == tot - 1) begin
              m_run[d] = en;
              m_p[d]   = 0;
            end else begin
              m_p[d]++;
            end
          end else if (en) begin
            m_run[d] = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        string p;
        p = (d == 0) ? "a." : "b.";
        chk({p, "de"},    32'(o_de[d]), 32'(e_de[d]));
        chk({p, "hsync"}, 32'(o_hs[d]), 32'(e_hs[d]));
        chk({p, "vsync"}, 32'(o_vs[d]), 32'(e_vs[d]));
        chk({p, "fs"},    32'(o_fs[d]), 32'(e_fs[d]));
        chk({p, "x"},     32'(o_x[d]),  32'(e_x[d]));
        chk({p, "y"},     32'(o_y[d]),  32'(e_y[d]));
        chk({p, "pixel"}, 32'(o_px[d]), 32'(e_px[d]));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] pats[4];
    bit found;
    int len;
    pats = '{2'd1, 2'd2, 2'd3, 2'd0};

    repeat (3) step();
    rst_n = 1'b1;
    repeat (6) step();

    // One full wide frame per pattern, scrambling the selection mid-frame.
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pattern_sel = pats[k];
      repeat (20) step();
      for (int i = 20; i < FRAME_B; i++) begin
        step();
        if ($urandom_range(0, 149) == 0) pattern_sel = 2'($urandom);
      end
    end

    // Alternate en drops (short ones land inside DRAIN, long ones reach IDLE).
    for (int s = 0; s < 8; s++) begin
      en  = (s % 2 == 1);
      if (en) len = $urandom_range(1, 2000);
      else    len = (s == 0 || $urandom_range(0, 1) == 1) ? $urandom_range(3600, 4000)
                                                          : $urandom_range(1, 200);
      for (int i = 0; i < len; i++) begin
        step();
        if ($urandom_range(0, 99) == 0) pattern_sel = 2'($urandom);
      end
    end

    // Asynchronous reset in the middle of an active line.
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12000 && !found; i++) begin
      step();
      found = e_de[1] && (e_x[1] == 12'd20);
    end
    chk("rst_wait", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst.b.de",    32'(de_b), 32'd0);
    chk("rst.b.x",     32'(x_b),  32'd0);
    chk("rst.b.hsync", 32'(hs_b), 32'd1);
    chk("rst.b.vsync", 32'(vs_b), 32'd1);
    chk("rst.b.pixel", 32'(px_b), 32'd0);
    chk("rst.a.de",    32'(de_a), 32'd0);
    chk("rst.a.hsync", 32'(hs_a), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    pattern_sel = 2'd1;
    repeat (2 * FRAME_B + 200) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
